// File: rtl/traffic_pkg.sv
// ============================================================================
//  Module   : traffic_pkg
//  Brief    : Shared light codes, phase codes and sensor-full helper for the
//             traffic_ctrl_n controller and its selection sub-module.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package traffic_pkg;

    typedef enum logic [1:0] {
        LT_RED    = 2'd0,
        LT_YELLOW = 2'd1,
        LT_GREEN  = 2'd2
    } light_e;

    typedef enum logic [1:0] {
        PH_GREEN  = 2'd0,
        PH_YELLOW = 2'd1,
        PH_ALLRED = 2'd2
    } phase_e;

    // Saturated crowding level for a sensor of the given width.
    function automatic int unsigned sens_full(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/traffic_sel.sv
// ============================================================================
//  Module   : traffic_sel
//  Brief    : Picks the unmasked road with the highest sensor value; ties go
//             to the lowest index. Purely combinational.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module traffic_sel #(
    parameter int NUM_ROADS = 4,
    parameter int SENS_W    = 3
) (
    input  logic [NUM_ROADS*SENS_W-1:0]  sensor_i,
    input  logic [NUM_ROADS-1:0]         mask_i,
    output logic [$clog2(NUM_ROADS)-1:0] sel_o
);

    localparam int c_idx_w = $clog2(NUM_ROADS);

    logic              w_found;
    logic [SENS_W-1:0] w_best;

    // Strict greater-than keeps the earliest (lowest-index) road on ties.
    always_comb begin
        w_found = 1'b0;
        w_best  = '0;
        sel_o   = '0;
        for (int r = 0; r < NUM_ROADS; r++) begin
            if (!mask_i[r] && (!w_found || (sensor_i[r*SENS_W +: SENS_W] > w_best))) begin
                w_found = 1'b1;
                w_best  = sensor_i[r*SENS_W +: SENS_W];
                sel_o   = c_idx_w'(r);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/traffic_ctrl_n.sv
// ============================================================================
//  Module   : traffic_ctrl_n
//  Brief    : N-road traffic light controller with round-based fair service,
//             sensor-driven selection and one-shot green extension.
//             Optional emergency pre-emption: TRAFFIC_EMERG_PREEMPT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module traffic_ctrl_n
    import traffic_pkg::*;
#(
    parameter int NUM_ROADS = 4,
    parameter int SENS_W    = 3,
    parameter int G_TIME    = 2,
    parameter int Y_TIME    = 3,
    parameter int AR_TIME   = 1
) (
    input  logic                         clock,
    input  logic                         clear,
    input  logic [NUM_ROADS*SENS_W-1:0]  sensor,
`ifdef TRAFFIC_EMERG_PREEMPT_EN
    input  logic                         emerg_req,
    input  logic [$clog2(NUM_ROADS)-1:0] emerg_road,
`endif
    output logic [2*NUM_ROADS-1:0]       lights,
    output logic [NUM_ROADS-1:0]         served,
    output logic [$clog2(NUM_ROADS)-1:0] active,
    output logic [1:0]                   phase
);

    localparam int c_idx_w = $clog2(NUM_ROADS);
    localparam int c_max_t = (G_TIME > Y_TIME) ? ((G_TIME > AR_TIME) ? G_TIME : AR_TIME)
                                               : ((Y_TIME > AR_TIME) ? Y_TIME : AR_TIME);
    localparam int c_cnt_w = (c_max_t > 1) ? $clog2(c_max_t) : 1;

    localparam logic [c_cnt_w-1:0]     c_g_load     = c_cnt_w'(G_TIME - 1);
    localparam logic [c_cnt_w-1:0]     c_y_load     = c_cnt_w'(Y_TIME - 1);
    localparam logic [c_cnt_w-1:0]     c_ar_load    = c_cnt_w'((AR_TIME > 0) ? AR_TIME - 1 : 0);
    localparam logic [SENS_W-1:0]      c_sens_full  = SENS_W'(sens_full(SENS_W));
    localparam logic [NUM_ROADS-1:0]   c_served_rst = NUM_ROADS'(1);
    localparam logic [2*NUM_ROADS-1:0] c_lights_rst = {{(2*NUM_ROADS-2){1'b0}}, LT_GREEN};

    phase_e                 phase_q,  phase_d;
    logic [c_idx_w-1:0]     active_q, active_d;
    logic [NUM_ROADS-1:0]   served_q, served_d;
    logic [c_cnt_w-1:0]     cnt_q,    cnt_d;
    logic                   ext_q,    ext_d;
    logic [2*NUM_ROADS-1:0] lights_q, lights_d;
`ifdef TRAFFIC_EMERG_PREEMPT_EN
    logic                   emg_pend_q, emg_pend_d;
    logic [c_idx_w-1:0]     emg_road_q, emg_road_d;
`endif

    logic [c_idx_w-1:0]     w_sel;
    logic [SENS_W-1:0]      w_sens_act;
    logic                   w_select;

    traffic_sel #(
        .NUM_ROADS (NUM_ROADS),
        .SENS_W    (SENS_W)
    ) u_sel (
        .sensor_i (sensor),
        .mask_i   (served_q),
        .sel_o    (w_sel)
    );

    assign w_sens_act = sensor[int'(active_q)*SENS_W +: SENS_W];

    always_comb begin
        phase_d  = phase_q;
        active_d = active_q;
        served_d = served_q;
        cnt_d    = cnt_q;
        ext_d    = ext_q;
        w_select = 1'b0;
`ifdef TRAFFIC_EMERG_PREEMPT_EN
        emg_pend_d = emg_pend_q;
        emg_road_d = emg_road_q;
`endif
        case (phase_q)
            PH_GREEN: begin
`ifdef TRAFFIC_EMERG_PREEMPT_EN
                if (emerg_req && (emerg_road != active_q)) begin
                    phase_d    = PH_YELLOW;
                    cnt_d      = c_y_load;
                    emg_pend_d = 1'b1;
                    emg_road_d = emerg_road;
                end else if (emerg_req) begin
                    cnt_d = cnt_q;  // emergency road holds green, timer frozen
                end else
`endif
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!ext_q && (w_sens_act == c_sens_full)) begin
                    cnt_d = c_g_load;
                    ext_d = 1'b1;
                end else begin
                    phase_d = PH_YELLOW;
                    cnt_d   = c_y_load;
                end
            end
            PH_YELLOW: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (AR_TIME > 0) begin
                    phase_d = PH_ALLRED;
                    cnt_d   = c_ar_load;
                end else begin
                    w_select = 1'b1;
                end
            end
            PH_ALLRED: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    w_select = 1'b1;
                end
            end
            default: begin
                phase_d = PH_GREEN;
                cnt_d   = c_g_load;
            end
        endcase

        if (w_select) begin
            phase_d = PH_GREEN;
            cnt_d   = c_g_load;
            ext_d   = 1'b0;
`ifdef TRAFFIC_EMERG_PREEMPT_EN
            if (emg_pend_q) begin
                active_d   = emg_road_q;
                emg_pend_d = 1'b0;
            end else
`endif
            if (&served_q) begin
                active_d = '0;
                served_d = c_served_rst;
            end else begin
                active_d = w_sel;
                served_d = served_q | (NUM_ROADS'(1) << w_sel);
            end
        end

        lights_d = '0;
        if (phase_d == PH_GREEN) begin
            lights_d[2*int'(active_d) +: 2] = LT_GREEN;
        end else if (phase_d == PH_YELLOW) begin
            lights_d[2*int'(active_d) +: 2] = LT_YELLOW;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            phase_q  <= PH_GREEN;
            active_q <= '0;
            served_q <= c_served_rst;
            cnt_q    <= c_g_load;
            ext_q    <= 1'b0;
            lights_q <= c_lights_rst;
`ifdef TRAFFIC_EMERG_PREEMPT_EN
            emg_pend_q <= 1'b0;
            emg_road_q <= '0;
`endif
        end else begin
            phase_q  <= phase_d;
            active_q <= active_d;
            served_q <= served_d;
            cnt_q    <= cnt_d;
            ext_q    <= ext_d;
            lights_q <= lights_d;
`ifdef TRAFFIC_EMERG_PREEMPT_EN
            emg_pend_q <= emg_pend_d;
            emg_road_q <= emg_road_d;
`endif
        end
    end

    assign lights = lights_q;
    assign served = served_q;
    assign active = active_q;
    assign phase  = phase_q;

endmodule

`default_nettype wire

// File: tb/tb_traffic_ctrl_n.sv
// ============================================================================
//  Module   : tb_traffic_ctrl_n
//  Brief    : Directed self-checking bench for traffic_ctrl_n (4 roads).
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_traffic_ctrl_n;

    logic        clk;
    logic        clear;
    logic [11:0] sensor;
    logic [7:0]  lights;
    logic [3:0]  served;
    logic [1:0]  active;
    logic [1:0]  phase;
`ifdef TRAFFIC_EMERG_PREEMPT_EN
    logic        emerg_req;
    logic [1:0]  emerg_road;
`endif

    traffic_ctrl_n #(
        .NUM_ROADS (4),
        .SENS_W    (3),
        .G_TIME    (2),
        .Y_TIME    (3),
        .AR_TIME   (1)
    ) dut (
        .clock      (clk),
        .clear      (clear),
        .sensor     (sensor),
`ifdef TRAFFIC_EMERG_PREEMPT_EN
        .emerg_req  (emerg_req),
        .emerg_road (emerg_road),
`endif
        .lights     (lights),
        .served     (served),
        .active     (active),
        .phase      (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    int         exp_order  [8];
    int         exp_glen   [8];
    logic [3:0] exp_served [8];
    logic       skip;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] lt(input int road, input int ph);
        logic [7:0] v;
        v = 8'h00;
        if (ph == 0)      v[2*road +: 2] = 2'd2;
        else if (ph == 1) v[2*road +: 2] = 2'd1;
        return v;
    endfunction

    // One-cycle clear, then check the reset state, which is cycle 0 of slot 0.
    task automatic do_reset();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("rst_lights", lights, 8'h02);
        chk("rst_served", served, 4'b0001);
        chk("rst_phase",  phase,  2'd0);
        chk("rst_active", active, 2'd0);
        skip = 1'b1;
    endtask

    task automatic run_slots(input int n);
        for (int s = 0; s < n; s++) begin
            for (int c = 0; c < exp_glen[s] + 4; c++) begin
                int ph;
                if (skip) skip = 1'b0;
                else      @(negedge clk);
                ph = (c < exp_glen[s]) ? 0 : ((c < exp_glen[s] + 3) ? 1 : 2);
                chk($sformatf("s%0d_c%0d_phase", s, c), phase, ph);
                chk($sformatf("s%0d_c%0d_lights", s, c), lights, lt(exp_order[s], ph));
                if (ph != 2) chk($sformatf("s%0d_c%0d_active", s, c), active, exp_order[s]);
                if (c == 0)  chk($sformatf("s%0d_served", s), served, exp_served[s]);
            end
        end
    endtask

    task automatic set_plan(input int o0, o1, o2, o3, o4,
                            input logic [3:0] s0, s1, s2, s3, s4);
        exp_order[0] = o0; exp_order[1] = o1; exp_order[2] = o2;
        exp_order[3] = o3; exp_order[4] = o4;
        exp_served[0] = s0; exp_served[1] = s1; exp_served[2] = s2;
        exp_served[3] = s3; exp_served[4] = s4;
        for (int i = 0; i < 8; i++) exp_glen[i] = 2;
    endtask

    initial begin
        clear  = 1'b1;
        sensor = '0;
        skip   = 1'b0;
`ifdef TRAFFIC_EMERG_PREEMPT_EN
        emerg_req  = 1'b0;
        emerg_road = 2'd0;
`endif
        repeat (2) @(negedge clk);

        // Distinct sensors: r1..r3 = 1,5,3
        sensor = {3'd3, 3'd5, 3'd1, 3'd0};
        set_plan(0, 2, 3, 1, 0, 4'b0001, 4'b0101, 4'b1101, 4'b1111, 4'b0001);
        do_reset();
        run_slots(5);

        // All tied at 3
        sensor = {3'd3, 3'd3, 3'd3, 3'd3};
        set_plan(0, 1, 2, 3, 0, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b0001);
        do_reset();
        run_slots(5);

        // Road 2 saturated: one extension only
        sensor = {3'd3, 3'd7, 3'd1, 3'd0};
        set_plan(0, 2, 3, 1, 0, 4'b0001, 4'b0101, 4'b1101, 4'b1111, 4'b0001);
        exp_glen[1] = 4;
        do_reset();
        run_slots(4);

        // Clear during road 3 yellow
        sensor = {3'd3, 3'd5, 3'd1, 3'd0};
        set_plan(0, 2, 3, 1, 0, 4'b0001, 4'b0101, 4'b1101, 4'b1111, 4'b0001);
        do_reset();
        run_slots(2);
        repeat (3) @(negedge clk);
        chk("mid_r3_yellow", lights, 8'h40);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("mid_rst_lights", lights, 8'h02);
        chk("mid_rst_served", served, 4'b0001);
        chk("mid_rst_phase",  phase,  2'd0);

`ifdef TRAFFIC_EMERG_PREEMPT_EN
        sensor = '0;
        set_plan(0, 1, 2, 3, 0, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b0001);
        do_reset();
        run_slots(1);
        @(negedge clk);
        chk("em_r1_green", lights, 8'h08);
        emerg_req  = 1'b1;
        emerg_road = 2'd3;
        @(negedge clk);
        chk("em_r1_yellow", lights, 8'h04);
        chk("em_r1_yphase", phase, 2'd1);
        repeat (2) @(negedge clk);
        chk("em_r1_y3", lights, 8'h04);
        @(negedge clk);
        chk("em_allred", lights, 8'h00);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("em_r3_hold%0d", i), lights, 8'h80);
            chk($sformatf("em_r3_served%0d", i), served, 4'b0011);
        end
        emerg_req = 1'b0;
        @(negedge clk);
        chk("em_r3_last_green", lights, 8'h80);
        @(negedge clk);
        chk("em_r3_yellow", lights, 8'h40);
        repeat (4) @(negedge clk);
        chk("em_next_r2", lights, 8'h20);
        chk("em_next_served", served, 4'b0111);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/traffic_ctrl_n.md
TRAFFIC_CTRL_N -- requirements
Module: traffic_ctrl_n

Interface
REQ-001 SHALL have parameter NUM_ROADS, default 4, number of approach roads (legal 2..8).
REQ-002 SHALL have parameter SENS_W, default 3, per-road sensor width.
REQ-003 SHALL have parameters G_TIME 2, Y_TIME 3, AR_TIME 1: green, yellow and all-red durations in clock cycles (G_TIME, Y_TIME >= 1; AR_TIME >= 0).
REQ-004 SHALL have one clock and a synchronous, active-high reset; ports: clock  in  1  rising-edge clock; clear  in  1  synchronous active-high reset.
REQ-005 SHALL have sensor  in  NUM_ROADS*SENS_W  packed crowding levels, road r at [r*SENS_W +: SENS_W].
REQ-006 SHALL have lights  out  2*NUM_ROADS  packed light codes, road r at [2r +: 2].
REQ-007 SHALL have served  out  NUM_ROADS  roads granted green in the current round.
REQ-008 SHALL have active  out  clog2(NUM_ROADS)  index of the road owning the current phase.
REQ-009 SHALL have phase  out  2  current phase: GREEN=0, YELLOW=1, ALLRED=2.

Function
REQ-010 SHALL encode lights as RED=0, YELLOW=1, GREEN=2; all non-active roads RED; active road GREEN/YELLOW per phase; all RED in ALLRED.
REQ-011 SHALL load a phase counter with duration-1 on phase entry, decrement each cycle, and leave the phase in the cycle after it reads 0, so each phase is visible exactly its duration.
REQ-012 SHALL sequence GREEN -> YELLOW -> ALLRED -> GREEN; with AR_TIME=0, YELLOW -> GREEN directly.
REQ-013 SHALL pick the next road at ALLRED exit (YELLOW exit if AR_TIME=0): the unserved road with the highest sensor value; ties go to the lowest index.
REQ-014 SHALL set the selected road's served bit on its GREEN entry.
REQ-015 SHALL, when served is all ones at selection, start a new round: select road 0 and set served to one-hot(0).
REQ-016 SHALL extend GREEN by one extra G_TIME when the active sensor equals 2^SENS_W-1 in the last GREEN cycle; at most one extension per grant.
REQ-017 SHALL sample sensors only at selection/extension decision cycles; sensor changes at other times have no effect.

Reset
REQ-018 SHALL, on any edge with clear high (including mid-phase), set phase=GREEN, active=0, served=one-hot(0), counter=G_TIME-1, extension flag cleared.
REQ-019 SHALL drive lights = road 0 GREEN, others RED, from the cycle after clear is sampled; clear overrides all other inputs.

Configuration
REQ-020 SHALL gate emergency pre-emption with macro TRAFFIC_EMERG_PREEMPT_EN.
REQ-021 SHALL, with the macro defined, add ports emerg_req  in  1  and emerg_road  in  clog2(NUM_ROADS).
REQ-022 SHALL, with emerg_req high and a different active road in GREEN, enter YELLOW next cycle and then select emerg_road after ALLRED, regardless of served.
REQ-023 SHALL hold GREEN with the counter frozen while emerg_req is high and emerg_road is active; normal timing resumes on release.
REQ-024 SHALL not set served bits for emergency grants.
REQ-025 SHALL, without the macro, omit both ports and all pre-emption logic.

Structure
REQ-026 SHALL place light codes, phase codes and the sensor-full constant in shared package traffic_pkg.
REQ-027 SHALL implement selection (masked max-with-lowest-index-tie) in a combinational sub-module traffic_sel.

Verification
REQ-028 SHALL check reset: clear high for 1 cycle -> lights=8'h02, served=4'b0001, phase=0.
REQ-029 SHALL check the timing sequence: sensors r1..r3 = 1,5,3 -> green order 0,2,3,1; each road shows 2 GREEN, 3 YELLOW and 1 ALLRED cycles (6-cycle slot).
REQ-030 SHALL check tie-breaking: all sensors 3 -> order 0,1,2,3, then road 0 again with served=4'b0001.
REQ-031 SHALL check extension: road 2 active with sensor 7 at its last GREEN cycle -> 4 GREEN cycles, then a normal YELLOW.
REQ-032 SHALL check mid-operation reset: clear during road 3 YELLOW -> next cycle lights=8'h02, served=4'b0001.
REQ-033 SHALL check pre-emption (macro defined): emerg_road=3 asserted during road 1 GREEN -> YELLOW next cycle, road 3 GREEN held until emerg_req drops, served[3] unchanged.
